mem_bus_master: RTL and testbench
=================================

Name: mem_bus_master

Overview:
- Synchronous bus master between the matrix execution engine and the shared system memory bus.
- Converts single-word write requests and 1–4 word read bursts from the engine into address/nRead/nWrite/data-bus cycles on that bus.
- Returns read data to the engine through a valid-only response channel.
- Owns bus direction (drive vs. release) and inserts turnaround cycles so it never contends with the main memory's tri-state driver.

Parameters:
- MAIN_MEM_EN, 4'h1: value of address[15:12] that selects main memory. Must equal the system MainMemEn.
- RD_WAIT_CYCLES, 1: extra cycles nRead is held per read beat before capture. Legal range 0–3.
- WORD_STRIDE, 16'h0080: address increment between burst beats; one 256-bit word.

Ports:
- Clk  in  1  system clock; all state changes on posedge.
- Reset  in  1  synchronous, active-high reset.
- req_valid  in  1  engine request valid.
- req_ready  out  1  block can accept a request this cycle.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  16  start address.
- req_len  in  2  read beats minus 1 (0..3); ignored for writes.
- req_wdata  in  256  write data.
- resp_valid  out  1  one-cycle pulse per read beat, or once per write/error completion.
- resp_rdata  out  256  captured read word; 0 on write/error responses.
- resp_last  out  1  final response of the request.
- resp_err  out  1  request rejected because address[15:12] != MAIN_MEM_EN.
- busy  out  1  FSM not in IDLE.
- address  out  16  bus address.
- nRead  out  1  active-low read strobe.
- nWrite  out  1  active-low write strobe.
- DataBus  inout  256  shared data bus; driven only in WR_DRIVE, otherwise high-Z.

Behaviour:
- All outputs are registered.
- While Reset is high, at each posedge:
  - address=0, nRead=1, nWrite=1, DataBus released;
  - req_ready=0, resp_valid=0, resp_rdata=0, resp_last=0, resp_err=0, busy=0;
  - FSM=IDLE, beat and wait counters=0.
- After Reset deasserts, req_ready=1 in IDLE only.
- A request is accepted on a posedge with req_valid & req_ready. The block latches addr, len, write and wdata at that edge; req_ready drops the same edge.
- FSM states: IDLE, ERR, RD_BEAT, WR_DRIVE, TURN.
- IDLE, on accept:
  - region mismatch -> ERR;
  - read -> RD_BEAT with address=req_addr, nRead=0, beat=0, wait=0;
  - write -> WR_DRIVE with address=req_addr, nWrite=0, DataBus=wdata.
- ERR: one cycle. resp_valid=1, resp_err=1, resp_last=1. No bus strobe is asserted. Next state TURN.
- RD_BEAT: nRead held low. Memory samples at the negedge and drives the bus from that negedge.
  - When wait==RD_WAIT_CYCLES, capture DataBus into resp_rdata at that posedge and pulse resp_valid; resp_last=1 if beat==len.
  - If beat<len, the same edge advances address by WORD_STRIDE (mod 2^16), beat+1, wait=0, and stays in RD_BEAT.
  - Otherwise the same edge sets nRead=1 and goes to TURN.
  - Beat latency: 1+RD_WAIT_CYCLES cycles. A 4-beat burst with default parameters takes 8 cycles of nRead low.
- WR_DRIVE: exactly one cycle. The memory writes at the mid-cycle negedge. Next edge: nWrite=1, DataBus released, resp_valid=1, resp_last=1, resp_rdata=0, go to TURN.
- TURN: one idle cycle, all strobes high and the bus released, so memory tri-states at the intervening negedge. Then IDLE with req_ready=1.
- Throughput: minimum spacing between requests is 1 accept cycle plus the transaction plus 1 TURN cycle.
- Address wrap: burst increment wraps 16'hFF80 -> 16'h0000. No region recheck mid-burst; a beat crossing out of region is still issued.
- req_valid while busy is ignored; the engine must hold it until req_ready.
- nRead and nWrite are never low in the same cycle.
- DataBus is never driven while nRead is low.
- Reset mid-operation: the next posedge returns to IDLE-with-reset values. Any partial burst is discarded and no further resp_valid is issued.
- resp_valid is a single-cycle pulse. There is no backpressure; the engine must always accept responses.

Test Plan:
- Reset, then read len=0 at 16'h1000 -> nRead low 2 cycles; one resp_valid with resp_last=1, resp_rdata=256'h0009_000c_0008_000d_0008_0003_000f_0009_000B_0013_0010_0007_000c_0005_000e_0006.
- Read len=3 at 16'h1480 -> address sequence 1480, 1500, 1580, 1600; four resp_valid pulses with data 0, 4, e, 0; resp_last on the 4th only.
- Write 16'h1100 with wdata=256'hABCD, then read 16'h1100 -> nWrite low exactly 1 cycle; TURN cycle with DataBus=Z; read returns 256'hABCD.
- Read at 16'h2000 -> no nRead/nWrite activity; one pulse with resp_err=1, resp_last=1; req_ready again 2 cycles later.
- Assert Reset during beat 2 of a len=3 burst -> next edge nRead=1, DataBus=Z, no further resp_valid; a new read of 16'h1000 afterwards returns word 0 (the value listed in the first scenario).
- RD_WAIT_CYCLES=0 with back-to-back write-then-read requests held valid -> one TURN cycle between them; no cycle with DataBus driven while nRead=0.

Source files
------------

// File: rtl/mem_bus_master.sv
// Bus master bridging engine requests onto the shared memory bus: single-word writes, 1-4 beat
// read bursts, region check, and a turnaround cycle after every transaction.
module mem_bus_master #(
    parameter logic [3:0]  MAIN_MEM_EN    = 4'h1,
    parameter int unsigned RD_WAIT_CYCLES = 1,
    parameter logic [15:0] WORD_STRIDE    = 16'h0080
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_write,
    input  logic [15:0]  req_addr,
    input  logic [1:0]   req_len,
    input  logic [255:0] req_wdata,
    output logic         resp_valid,
    output logic [255:0] resp_rdata,
    output logic         resp_last,
    output logic         resp_err,
    output logic         busy,
    output logic [15:0]  address,
    output logic         nRead,
    output logic         nWrite,
    inout  wire  [255:0] DataBus
);

    localparam logic [1:0] WaitMax = 2'(RD_WAIT_CYCLES);

    typedef enum logic [2:0] {StIdle, StErr, StRdBeat, StWrDrive, StTurn} state_e;

    state_e         state_q;
    logic [1:0]     beat_q, wait_q, len_q;
    logic [15:0]    addr_q;
    logic [255:0]   wdata_q, rdata_q;
    logic           ready_q, valid_q, last_q, err_q, busy_q;
    logic           rd_n_q, wr_n_q, bus_oe_q;
    logic           accept;

    assign accept  = req_valid & ready_q;
    // Only WR_DRIVE drives the bus; every other state leaves it to the memory.
    assign DataBus = bus_oe_q ? wdata_q : 'z;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= StIdle;
            beat_q   <= '0;
            wait_q   <= '0;
            len_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            ready_q  <= 1'b0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            rd_n_q   <= 1'b1;
            wr_n_q   <= 1'b1;
            bus_oe_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    ready_q <= 1'b1;
                    if (accept) begin
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        len_q   <= req_len;
                        beat_q  <= '0;
                        wait_q  <= '0;
                        if (req_addr[15:12] != MAIN_MEM_EN) begin
                            // Error response is presented during the ERR cycle itself.
                            state_q <= StErr;
                            valid_q <= 1'b1;
                            err_q   <= 1'b1;
                            last_q  <= 1'b1;
                            rdata_q <= '0;
                        end else if (req_write) begin
                            state_q  <= StWrDrive;
                            addr_q   <= req_addr;
                            wdata_q  <= req_wdata;
                            wr_n_q   <= 1'b0;
                            bus_oe_q <= 1'b1;
                        end else begin
                            state_q <= StRdBeat;
                            addr_q  <= req_addr;
                            rd_n_q  <= 1'b0;
                        end
                    end
                end
                StErr: begin
                    state_q <= StTurn;
                end
                StRdBeat: begin
                    if (wait_q == WaitMax) begin
                        rdata_q <= DataBus;
                        valid_q <= 1'b1;
                        if (beat_q != len_q) begin
                            addr_q <= addr_q + WORD_STRIDE;
                            beat_q <= beat_q + 2'd1;
                            wait_q <= '0;
                        end else begin
                            last_q  <= 1'b1;
                            rd_n_q  <= 1'b1;
                            state_q <= StTurn;
                        end
                    end else begin
                        wait_q <= wait_q + 2'd1;
                    end
                end
                StWrDrive: begin
                    wr_n_q   <= 1'b1;
                    bus_oe_q <= 1'b0;
                    valid_q  <= 1'b1;
                    last_q   <= 1'b1;
                    rdata_q  <= '0;
                    state_q  <= StTurn;
                end
                StTurn: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign req_ready  = ready_q;
    assign resp_valid = valid_q;
    assign resp_rdata = rdata_q;
    assign resp_last  = last_q;
    assign resp_err   = err_q;
    assign busy       = busy_q;
    assign address    = addr_q;
    assign nRead      = rd_n_q;
    assign nWrite     = wr_n_q;

endmodule

// File: tb/tb_mem_bus_master.sv
// Bench for mem_bus_master: behavioural memory on the tri-state bus, request-level reference
// model with response scoreboard, plus a zero-wait-state instance for back-to-back traffic.
module tb_mem_bus_master;

    typedef struct {
        logic [255:0] rdata;
        logic         last;
        logic         err;
    } resp_t;

    typedef struct {
        logic         wr;
        logic [15:0]  addr;
        logic [1:0]   len;
        logic [255:0] wdata;
        int           rd_lo;
        int           wr_lo;
        int           rdy;
    } vec_t;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    function automatic void chk(input string name, input logic [255:0] act,
                                input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // ---------------- instance 0: default parameters ----------------
    logic         rst0 = 1'b1, rv0 = 1'b0, rw0 = 1'b0;
    logic [15:0]  ra0 = '0;
    logic [1:0]   rl0 = '0;
    logic [255:0] wd0 = '0;
    logic         rr0, vo0, last0, err0, busy0, nrd0, nwr0;
    logic [255:0] rdata0;
    logic [15:0]  addr0;
    wire  [255:0] bus0;

    mem_bus_master dut0 (
        .Clk(Clk), .Reset(rst0), .req_valid(rv0), .req_ready(rr0), .req_write(rw0),
        .req_addr(ra0), .req_len(rl0), .req_wdata(wd0), .resp_valid(vo0),
        .resp_rdata(rdata0), .resp_last(last0), .resp_err(err0), .busy(busy0),
        .address(addr0), .nRead(nrd0), .nWrite(nwr0), .DataBus(bus0)
    );

    logic [255:0] mem0 [512];
    logic         mem0_drv = 1'b0;
    logic [255:0] mem0_out = '0;
    assign bus0 = mem0_drv ? mem0_out : 'z;

    always @(negedge Clk) begin
        if (nwr0 === 1'b0) mem0[addr0[15:7]] <= bus0;
        if (nrd0 === 1'b0) begin
            mem0_drv <= 1'b1;
            mem0_out <= mem0[addr0[15:7]];
        end else begin
            mem0_drv <= 1'b0;
        end
    end

    // Reference model: memory image and expected responses per request.
    logic [255:0] ref_mem [512];
    resp_t        exp_q[$];

    function automatic void model_req(input logic wr, input logic [15:0] a, input logic [1:0] l,
                                      input logic [255:0] d);
        resp_t       r;
        logic [15:0] ai;
        r.err = 1'b0;
        if (a[15:12] != 4'h1) begin
            r.rdata = '0; r.last = 1'b1; r.err = 1'b1;
            exp_q.push_back(r);
        end else if (wr) begin
            ref_mem[a[15:7]] = d;
            r.rdata = '0; r.last = 1'b1;
            exp_q.push_back(r);
        end else begin
            for (int i = 0; i <= int'(l); i++) begin
                ai = a + 16'(i * 128);
                r.rdata = ref_mem[ai[15:7]];
                r.last  = (i == int'(l));
                exp_q.push_back(r);
            end
        end
    endfunction

    logic        mon_en = 1'b0;
    int          rd_lo = 0, wr_lo = 0;
    logic [15:0] addr_log[$];

    always @(negedge Clk) begin : mon0
        resp_t r;
        if (mon_en) begin
            if (!nrd0) begin rd_lo++; addr_log.push_back(addr0); end
            if (!nwr0) wr_lo++;
            chk("strobe_excl0", 256'(!nrd0 && !nwr0), 256'(0));
            chk("bus_drive0", 256'(dut0.bus_oe_q && !(!nwr0 && nrd0)), 256'(0));
            if (vo0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_resp0", 256'(vo0), 256'(0));
                end else begin
                    r = exp_q.pop_front();
                    chk("resp_rdata0", rdata0, r.rdata);
                    chk("resp_last0", 256'(last0), 256'(r.last));
                    chk("resp_err0", 256'(err0), 256'(r.err));
                end
            end
        end
    end

    task automatic do_req(input logic w, input logic [15:0] a, input logic [1:0] l,
                          input logic [255:0] d, output int rdy);
        int n;
        n = 0;
        while (!rr0 && n < 50) begin @(posedge Clk); #1; n++; end
        if (!rr0) begin
            chk("ready_timeout0", 256'(rr0), 256'(1));
            rdy = -1;
            return;
        end
        model_req(w, a, l, d);
        rd_lo = 0; wr_lo = 0; addr_log.delete();
        rv0 = 1'b1; rw0 = w; ra0 = a; rl0 = l; wd0 = d;
        @(posedge Clk); #1;
        rv0 = 1'b0;
        n = 0;
        while (!rr0 && n < 50) begin @(posedge Clk); #1; n++; end
        rdy = n;
    endtask

    // ---------------- instance 1: zero wait states, region F ----------------
    logic         rst1 = 1'b1, rv1 = 1'b0, rw1 = 1'b0;
    logic [15:0]  ra1 = '0;
    logic [1:0]   rl1 = '0;
    logic [255:0] wd1 = '0;
    logic         rr1, vo1, last1, err1, busy1, nrd1, nwr1;
    logic [255:0] rdata1;
    logic [15:0]  addr1;
    wire  [255:0] bus1;

    mem_bus_master #(.MAIN_MEM_EN(4'hF), .RD_WAIT_CYCLES(0), .WORD_STRIDE(16'h0080)) dut1 (
        .Clk(Clk), .Reset(rst1), .req_valid(rv1), .req_ready(rr1), .req_write(rw1),
        .req_addr(ra1), .req_len(rl1), .req_wdata(wd1), .resp_valid(vo1),
        .resp_rdata(rdata1), .resp_last(last1), .resp_err(err1), .busy(busy1),
        .address(addr1), .nRead(nrd1), .nWrite(nwr1), .DataBus(bus1)
    );

    logic [255:0] mem1 [512];
    logic         mem1_drv = 1'b0;
    logic [255:0] mem1_out = '0;
    assign bus1 = mem1_drv ? mem1_out : 'z;

    always @(negedge Clk) begin
        if (nwr1 === 1'b0) mem1[addr1[15:7]] <= bus1;
        if (nrd1 === 1'b0) begin
            mem1_drv <= 1'b1;
            mem1_out <= mem1[addr1[15:7]];
        end else begin
            mem1_drv <= 1'b0;
        end
    end

    function automatic logic [255:0] pat1(input int idx);
        return {8{32'(idx) * 32'h9E37_79B1}};
    endfunction

    logic        mon1_en = 1'b0;
    logic        done1 = 1'b0;
    int          rd_lo1 = 0;
    logic [15:0] addr_log1[$];
    resp_t       log1[$];

    always @(negedge Clk) begin : mon1
        resp_t r;
        if (mon1_en) begin
            if (!nrd1) begin rd_lo1++; addr_log1.push_back(addr1); end
            chk("strobe_excl1", 256'(!nrd1 && !nwr1), 256'(0));
            chk("bus_drive1", 256'(dut1.bus_oe_q && !(!nwr1 && nrd1)), 256'(0));
            if (vo1) begin
                r.rdata = rdata1; r.last = last1; r.err = err1;
                log1.push_back(r);
            end
        end
    end

    initial begin : stim1
        int     k;
        logic [255:0] x;
        x = 256'hDEAD_BEEF_0123_4567;
        for (int i = 0; i < 512; i++) mem1[i] = pat1(i);
        repeat (3) @(posedge Clk);
        #1;
        rst1 = 1'b0;
        mon1_en = 1'b1;
        k = 0;
        while (!rr1 && k < 20) begin @(posedge Clk); #1; k++; end
        chk("ready1_after_reset", 256'(rr1), 256'(1));
        // Write then read with req_valid held high throughout.
        rv1 = 1'b1; rw1 = 1'b1; ra1 = 16'hF100; rl1 = 2'd0; wd1 = x;
        @(posedge Clk); #1;
        rw1 = 1'b0;
        k = 0;
        do begin @(posedge Clk); #1; k++; end while (!rr1 && k < 20);
        chk("b2b_gap", 256'(k), 256'(2));
        @(posedge Clk); #1;
        rv1 = 1'b0;
        k = 0;
        while (log1.size() < 2 && k < 20) begin @(posedge Clk); #1; k++; end
        chk("b2b_resp_count", 256'(log1.size()), 256'(2));
        if (log1.size() >= 2) begin
            chk("b2b_wr_rdata", log1[0].rdata, '0);
            chk("b2b_wr_last", 256'(log1[0].last), 256'(1));
            chk("b2b_rd_rdata", log1[1].rdata, x);
            chk("b2b_rd_last", 256'(log1[1].last), 256'(1));
        end
        // Burst across the top of the address space.
        k = 0;
        while (!rr1 && k < 20) begin @(posedge Clk); #1; k++; end
        rd_lo1 = 0; addr_log1.delete();
        rv1 = 1'b1; rw1 = 1'b0; ra1 = 16'hFF80; rl1 = 2'd1;
        @(posedge Clk); #1;
        rv1 = 1'b0;
        k = 0;
        while (log1.size() < 4 && k < 20) begin @(posedge Clk); #1; k++; end
        chk("wrap_resp_count", 256'(log1.size()), 256'(4));
        chk("wrap_rd_lo", 256'(rd_lo1), 256'(2));
        if (addr_log1.size() == 2) begin
            chk("wrap_addr0", 256'(addr_log1[0]), 256'(16'hFF80));
            chk("wrap_addr1", 256'(addr_log1[1]), 256'(16'h0000));
        end else begin
            chk("wrap_addr_count", 256'(addr_log1.size()), 256'(2));
        end
        if (log1.size() >= 4) begin
            chk("wrap_beat0", log1[2].rdata, pat1(9'h1FF));
            chk("wrap_last0", 256'(log1[2].last), 256'(0));
            chk("wrap_beat1", log1[3].rdata, pat1(0));
            chk("wrap_last1", 256'(log1[3].last), 256'(1));
        end
        done1 = 1'b1;
    end

    // ---------------- main sequence on instance 0 ----------------
    vec_t vecs[9];
    logic [15:0] burst_a [4];

    initial begin : stim0
        int           rdy, n, e_rd, e_wr, e_rdy;
        logic         w, bad;
        logic [15:0]  a;
        logic [1:0]   l;
        logic [255:0] d, v;

        for (int i = 0; i < 512; i++) begin
            for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
            mem0[i] = v; ref_mem[i] = v;
        end
        v = 256'h0009_000c_0008_000d_0008_0003_000f_0009_000B_0013_0010_0007_000c_0005_000e_0006;
        mem0[9'h020] = v;      ref_mem[9'h020] = v;
        mem0[9'h029] = 256'h0; ref_mem[9'h029] = 256'h0;
        mem0[9'h02A] = 256'h4; ref_mem[9'h02A] = 256'h4;
        mem0[9'h02B] = 256'hE; ref_mem[9'h02B] = 256'hE;
        mem0[9'h02C] = 256'h0; ref_mem[9'h02C] = 256'h0;
        burst_a = '{16'h1480, 16'h1500, 16'h1580, 16'h1600};

        vecs[0] = '{1'b0, 16'h1000, 2'd0, 256'h0,      2, 0, 3};
        vecs[1] = '{1'b0, 16'h1480, 2'd3, 256'h0,      8, 0, 9};
        vecs[2] = '{1'b1, 16'h1100, 2'd0, 256'hABCD,   0, 1, 2};
        vecs[3] = '{1'b0, 16'h1100, 2'd0, 256'h0,      2, 0, 3};
        vecs[4] = '{1'b0, 16'h2000, 2'd0, 256'h0,      0, 0, 2};
        vecs[5] = '{1'b1, 16'h3000, 2'd0, 256'h1234,   0, 0, 2};
        vecs[6] = '{1'b0, 16'h1F80, 2'd1, 256'h0,      4, 0, 5};
        vecs[7] = '{1'b1, 16'h1480, 2'd2, 256'hFEED,   0, 1, 2};
        vecs[8] = '{1'b0, 16'h1480, 2'd3, 256'h0,      8, 0, 9};

        repeat (3) @(posedge Clk);
        #1;
        chk("rst_address", 256'(addr0), 256'(0));
        chk("rst_nread", 256'(nrd0), 256'(1));
        chk("rst_nwrite", 256'(nwr0), 256'(1));
        chk("rst_ready", 256'(rr0), 256'(0));
        chk("rst_valid", 256'(vo0), 256'(0));
        chk("rst_rdata", rdata0, '0);
        chk("rst_last_err", 256'({last0, err0}), 256'(0));
        chk("rst_busy", 256'(busy0), 256'(0));
        chk("rst_bus_oe", 256'(dut0.bus_oe_q), 256'(0));
        rst0 = 1'b0;
        mon_en = 1'b1;
        @(posedge Clk); #1;
        chk("ready_after_reset", 256'(rr0), 256'(1));

        for (int i = 0; i < 9; i++) begin
            do_req(vecs[i].wr, vecs[i].addr, vecs[i].len, vecs[i].wdata, rdy);
            chk($sformatf("vec%0d_ready_cycles", i), 256'(rdy), 256'(vecs[i].rdy));
            chk($sformatf("vec%0d_nread_cycles", i), 256'(rd_lo), 256'(vecs[i].rd_lo));
            chk($sformatf("vec%0d_nwrite_cycles", i), 256'(wr_lo), 256'(vecs[i].wr_lo));
            chk($sformatf("vec%0d_resp_drain", i), 256'(exp_q.size()), 256'(0));
            chk($sformatf("vec%0d_busy_idle", i), 256'(busy0), 256'(0));
            if (vecs[i].addr == 16'h1480 && !vecs[i].wr && vecs[i].len == 2'd3) begin
                if (addr_log.size() == 8) begin
                    for (int b = 0; b < 4; b++)
                        chk($sformatf("vec%0d_addr_beat%0d", i, b),
                            256'(addr_log[2*b]), 256'(burst_a[b]));
                end else begin
                    chk("burst_addr_count", 256'(addr_log.size()), 256'(8));
                end
            end
        end

        // Reset during beat 2 of a 4-beat burst: only beats 0 and 1 may respond.
        n = 0;
        while (!rr0 && n < 50) begin @(posedge Clk); #1; n++; end
        model_req(1'b0, 16'h1480, 2'd3, '0);
        void'(exp_q.pop_back());
        void'(exp_q.pop_back());
        rv0 = 1'b1; rw0 = 1'b0; ra0 = 16'h1480; rl0 = 2'd3;
        @(posedge Clk); #1;
        rv0 = 1'b0;
        repeat (4) @(posedge Clk);
        #1;
        chk("midrst_nread_low_before", 256'(nrd0), 256'(0));
        rst0 = 1'b1;
        @(posedge Clk); #1;
        chk("midrst_nread", 256'(nrd0), 256'(1));
        chk("midrst_bus_oe", 256'(dut0.bus_oe_q), 256'(0));
        chk("midrst_valid", 256'(vo0), 256'(0));
        chk("midrst_busy", 256'(busy0), 256'(0));
        chk("midrst_ready", 256'(rr0), 256'(0));
        rst0 = 1'b0;
        repeat (4) @(posedge Clk);
        #1;
        chk("midrst_resp_drain", 256'(exp_q.size()), 256'(0));
        do_req(1'b0, 16'h1000, 2'd0, '0, rdy);
        chk("postrst_ready_cycles", 256'(rdy), 256'(3));

        // Randomised traffic against the request-level model.
        for (int i = 0; i < 40; i++) begin
            a = 16'($urandom);
            if ($urandom_range(0, 4) != 0) a[15:12] = 4'h1;
            a[11:10] = 2'b00;
            w = 1'($urandom);
            l = 2'($urandom);
            for (int k = 0; k < 8; k++) d[k*32 +: 32] = $urandom;
            bad   = (a[15:12] != 4'h1);
            e_rd  = (bad || w) ? 0 : (int'(l) + 1) * 2;
            e_wr  = (!bad && w) ? 1 : 0;
            e_rdy = (bad || w) ? 2 : (int'(l) + 1) * 2 + 1;
            do_req(w, a, l, d, rdy);
            chk($sformatf("rnd%0d_ready_cycles", i), 256'(rdy), 256'(e_rdy));
            chk($sformatf("rnd%0d_nread_cycles", i), 256'(rd_lo), 256'(e_rd));
            chk($sformatf("rnd%0d_nwrite_cycles", i), 256'(wr_lo), 256'(e_wr));
        end
        repeat (3) @(posedge Clk);
        #1;
        chk("final_resp_drain", 256'(exp_q.size()), 256'(0));

        n = 0;
        while (!done1 && n < 2000) begin @(posedge Clk); n++; end
        chk("inst1_done", 256'(done1), 256'(1));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
